// File: rtl/oneshot_event_arbiter.sv
// -----------------------------------------------------------------------------
// oneshot_event_arbiter
//
// Collects one-cycle event pulses from NUM_CH asynchronous trap oneshots. Each
// event sets a per-channel pending flag. A round-robin arbiter offers one
// pending channel at a time to a consumer. After the consumer accepts, the
// arbiter sends a one-cycle re-arm pulse back to that channel's trap. An event
// that arrives while its channel is already pending is counted as a "miss" in
// a saturating per-channel counter.
//
// Ports
//   outclk       in   system clock; all state changes on its rising edge
//   reset        in   asynchronous, active-high reset
//   event_pulse  in   [NUM_CH]  one-cycle event pulses, one per channel
//   trap_clear   out  [NUM_CH]  one-cycle re-arm pulse to the serviced trap
//   out_valid    out  an event is being offered on out_id
//   out_id       out  [ID_W]    channel index of the offered event
//   out_ready    in   consumer accepts the offered event
//   pending      out  [NUM_CH]  per-channel pending-event flags
//   cnt_sel      in   [ID_W]    selects which miss counter drives cnt_out
//   cnt_out      out  [CNT_W]   selected miss counter (combinational)
//   cnt_clr      in   synchronous clear of all miss counters
//   fsm_state    out  [2]       current arbiter state, for observation
//
// Handshake: out_valid/out_ready follow strict valid/ready rules. out_valid is
// registered. Once raised, it stays high with out_id unchanged until the
// consumer accepts. An accept is an edge where out_valid=1 and out_ready=1.
// out_ready has no effect while out_valid=0.
// -----------------------------------------------------------------------------
module oneshot_event_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  localparam int ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              outclk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] event_pulse,
  output logic [NUM_CH-1:0] trap_clear,
  output logic              out_valid,
  output logic [ID_W-1:0]   out_id,
  input  logic              out_ready,
  output logic [NUM_CH-1:0] pending,
  input  logic [ID_W-1:0]   cnt_sel,
  output logic [CNT_W-1:0]  cnt_out,
  input  logic              cnt_clr,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  miss_cnt [NUM_CH];

  logic              handshake;
  logic [NUM_CH-1:0] accept_mask;
  logic [NUM_CH-1:0] pending_next;
  logic [NUM_CH-1:0] miss_hit;
  logic [NUM_CH-1:0] grant_onehot;
  logic              pick_found;
  logic [ID_W-1:0]   pick_id;
  logic [ID_W:0]     scan_idx;
  logic [ID_W-1:0]   rr_next;

  assign fsm_state = state;

  // An accept happens only while the event is actually being offered.
  assign handshake = (state == ST_OFFER) && out_ready;

  // One-hot decode of the registered channel index.
  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (out_id == ID_W'(i)) grant_onehot[i] = 1'b1;
    end
  end

  assign accept_mask = handshake ? grant_onehot : '0;

  // A new pulse always (re)sets pending. This covers the case where a pulse
  // arrives on the same edge the channel is accepted: the new event wins.
  // A miss counts only when the old event is still waiting, i.e. the channel
  // is pending and is not being accepted on this edge.
  always_comb begin
    pending_next = event_pulse | (pending & ~accept_mask);
    miss_hit     = event_pulse & pending & ~accept_mask;
  end

  // Round-robin pick: find the first pending bit at or above rr_ptr,
  // wrapping modulo NUM_CH. This works for any NUM_CH, not only powers of two.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan_idx = {1'b0, rr_ptr} + (ID_W + 1)'(k);
      if (scan_idx >= (ID_W + 1)'(NUM_CH)) scan_idx = scan_idx - (ID_W + 1)'(NUM_CH);
      if (!pick_found && pending[scan_idx[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = scan_idx[ID_W-1:0];
      end
    end
  end

  // The pointer moves to the channel just after the one that was served.
  assign rr_next = (out_id == ID_W'(NUM_CH - 1)) ? '0 : out_id + ID_W'(1);

  // Pending flags.
  always_ff @(posedge outclk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // Saturating miss counters. A clear wins over an increment on the same edge.
  always_ff @(posedge outclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) miss_cnt[i] <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < NUM_CH; i++) miss_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (miss_hit[i] && (miss_cnt[i] != '1)) miss_cnt[i] <= miss_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Arbiter FSM. out_valid and trap_clear are registered. Because the reset
  // is asynchronous, asserting it drops both immediately, even between edges.
  // A single grant takes IDLE -> OFFER -> CLEAR -> IDLE, so at most one grant
  // completes every three cycles.
  always_ff @(posedge outclk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      out_valid  <= 1'b0;
      out_id     <= '0;
      trap_clear <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          trap_clear <= '0;
          if (pick_found) begin
            out_id    <= pick_id;
            out_valid <= 1'b1;
            state     <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            trap_clear <= grant_onehot;
            rr_ptr     <= rr_next;
            state      <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          trap_clear <= '0;
          state      <= ST_IDLE;
        end
        default: begin
          out_valid  <= 1'b0;
          trap_clear <= '0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  // Miss counter readback.
  always_comb begin
    cnt_out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cnt_sel == ID_W'(i)) cnt_out = miss_cnt[i];
    end
  end

endmodule

// File: tb/tb_oneshot_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_oneshot_event_arbiter
//
// Directed scenarios followed by a randomized run. Every cycle the DUT is
// compared against a transaction-level reference model. The model tracks
// which channel is offered, which channel is being re-armed, the pending set
// and the miss counts, using plain ints and arrays.
// -----------------------------------------------------------------------------
module tb_oneshot_event_arbiter;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 8;
  localparam int ID_W    = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic              outclk;
  logic              reset;
  logic [NUM_CH-1:0] event_pulse;
  logic [NUM_CH-1:0] trap_clear;
  logic              out_valid;
  logic [ID_W-1:0]   out_id;
  logic              out_ready;
  logic [NUM_CH-1:0] pending;
  logic [ID_W-1:0]   cnt_sel;
  logic [CNT_W-1:0]  cnt_out;
  logic              cnt_clr;
  logic [1:0]        fsm_state;

  initial outclk = 1'b0;
  always #5 outclk = ~outclk;

  oneshot_event_arbiter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .outclk      (outclk),
    .reset       (reset),
    .event_pulse (event_pulse),
    .trap_clear  (trap_clear),
    .out_valid   (out_valid),
    .out_id      (out_id),
    .out_ready   (out_ready),
    .pending     (pending),
    .cnt_sel     (cnt_sel),
    .cnt_out     (cnt_out),
    .cnt_clr     (cnt_clr),
    .fsm_state   (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int g_id[$];
  int g_cyc[$];

  // Reference model. -1 means "no channel".
  int m_offer;
  int m_clear;
  int m_id;
  int m_rr;
  bit m_pend [NUM_CH];
  int m_cnt  [NUM_CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_offer = -1;
    m_clear = -1;
    m_id    = 0;
    m_rr    = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_pend[i] = 1'b0;
      m_cnt[i]  = 0;
    end
  endfunction

  // One rising edge of the reference model, using the inputs seen at that edge.
  function automatic void model_edge(input logic [NUM_CH-1:0] ev, input logic rdy, input logic clr);
    bit old_p [NUM_CH];
    bit hs;
    int nxt_offer;
    int nxt_clear;
    int c;
    old_p     = m_pend;
    hs        = (m_offer >= 0) && rdy;
    nxt_offer = -1;
    nxt_clear = -1;
    if (m_offer >= 0) begin
      if (rdy) nxt_clear = m_offer;
      else     nxt_offer = m_offer;
    end else if (m_clear < 0) begin
      for (int k = 0; k < NUM_CH; k++) begin
        c = (m_rr + k) % NUM_CH;
        if (nxt_offer < 0 && old_p[c]) nxt_offer = c;
      end
      if (nxt_offer >= 0) m_id = nxt_offer;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      bit accepted;
      accepted = hs && (i == m_offer);
      if (ev[i] && old_p[i] && !accepted && m_cnt[i] < CNT_MAX) m_cnt[i]++;
      if (ev[i])         m_pend[i] = 1'b1;
      else if (accepted) m_pend[i] = 1'b0;
    end
    if (clr) for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
    if (hs) m_rr = (m_offer + 1) % NUM_CH;
    m_offer = nxt_offer;
    m_clear = nxt_clear;
  endfunction

  task automatic check_all();
    logic [NUM_CH-1:0] p;
    logic [NUM_CH-1:0] t;
    p = '0;
    t = '0;
    for (int i = 0; i < NUM_CH; i++) p[i] = m_pend[i];
    if (m_clear >= 0) t[m_clear] = 1'b1;
    check("out_valid",  32'(out_valid),  32'(m_offer >= 0));
    check("out_id",     32'(out_id),     32'(m_id));
    check("trap_clear", 32'(trap_clear), 32'(t));
    check("pending",    32'(pending),    32'(p));
    check("cnt_out",    32'(cnt_out),    32'(m_cnt[cnt_sel]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input logic [NUM_CH-1:0] ev, input logic rdy, input logic clr);
    event_pulse = ev;
    out_ready   = rdy;
    cnt_clr     = clr;
    if (out_valid && rdy) begin
      g_id.push_back(int'(out_id));
      g_cyc.push_back(cyc);
    end
    @(posedge outclk);
    model_edge(ev, rdy, clr);
    cyc++;
    #1;
    event_pulse = '0;
    cnt_clr     = 1'b0;
    check_all();
  endtask

  task automatic apply_reset();
    reset       = 1'b1;
    event_pulse = '0;
    out_ready   = 1'b0;
    cnt_clr     = 1'b0;
    #3;
    model_reset();
    check("rst_valid",   32'(out_valid),  32'd0);
    check("rst_pending", 32'(pending),    32'd0);
    check("rst_trap",    32'(trap_clear), 32'd0);
    check("rst_id",      32'(out_id),     32'd0);
    check_all();
    @(negedge outclk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset       = 1'b1;
    event_pulse = '0;
    out_ready   = 1'b0;
    cnt_sel     = '0;
    cnt_clr     = 1'b0;
    model_reset();

    // Single pulse on ch2 with the consumer always ready.
    apply_reset();
    cnt_sel = 2'd2;
    tick(4'b0100, 1'b1, 1'b0);
    check("c2_pend_k",   32'(pending),   32'h4);
    check("c2_valid_k",  32'(out_valid), 32'd0);
    tick(4'b0000, 1'b1, 1'b0);
    check("c2_valid_k1", 32'(out_valid), 32'd1);
    check("c2_id",       32'(out_id),    32'd2);
    tick(4'b0000, 1'b1, 1'b0);
    check("c2_trap",     32'(trap_clear), 32'h4);
    check("c2_pend0",    32'(pending),    32'h0);
    tick(4'b0000, 1'b1, 1'b0);
    check("c2_trap_1cy", 32'(trap_clear), 32'h0);

    // All four channels at once: grants 0,1,2,3 spaced three cycles apart.
    apply_reset();
    g_id.delete();
    g_cyc.delete();
    tick(4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 13; i++) tick(4'b0000, 1'b1, 1'b0);
    check("rr_count", 32'(g_id.size()), 32'd4);
    if (g_id.size() == 4) begin
      for (int i = 0; i < 4; i++) check("rr_order", 32'(g_id[i]), 32'(i));
      for (int i = 1; i < 4; i++) check("rr_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);
    end

    // Stalled consumer: the offer holds, misses count, and the counter saturates.
    apply_reset();
    cnt_sel = 2'd1;
    tick(4'b0010, 1'b0, 1'b0);
    tick(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick((i == 2 || i == 5 || i == 8) ? 4'b0010 : 4'b0000, 1'b0, 1'b0);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_id",    32'(out_id),    32'd1);
    end
    check("miss3", 32'(cnt_out), 32'd3);
    for (int i = 0; i < 300; i++) tick(4'b0010, 1'b0, 1'b0);
    check("miss_sat", 32'(cnt_out), 32'(CNT_MAX));
    tick(4'b0010, 1'b0, 1'b1);
    check("clr_wins", 32'(cnt_out), 32'd0);
    tick(4'b0000, 1'b1, 1'b0);
    tick(4'b0000, 1'b1, 1'b0);

    // A ch3 pulse on its own handshake edge keeps ch3 pending and counts no miss.
    apply_reset();
    cnt_sel = 2'd3;
    tick(4'b1000, 1'b1, 1'b0);
    tick(4'b0000, 1'b1, 1'b0);
    tick(4'b1000, 1'b1, 1'b0);
    check("hs_pend3", 32'(pending[3]), 32'd1);
    check("hs_cnt3",  32'(cnt_out),    32'd0);
    check("hs_trap3", 32'(trap_clear), 32'h8);
    tick(4'b0000, 1'b1, 1'b0);
    tick(4'b0000, 1'b1, 1'b0);
    check("reoffer_valid", 32'(out_valid), 32'd1);
    check("reoffer_id",    32'(out_id),    32'd3);
    for (int i = 0; i < 3; i++) tick(4'b0000, 1'b1, 1'b0);

    // Reset between edges while ch2 is offered with rr_ptr pointing at ch2.
    apply_reset();
    tick(4'b0010, 1'b1, 1'b0);
    tick(4'b0000, 1'b1, 1'b0);
    tick(4'b0000, 1'b1, 1'b0);
    tick(4'b0000, 1'b0, 1'b0);
    tick(4'b1100, 1'b0, 1'b0);
    tick(4'b0000, 1'b0, 1'b0);
    check("pre_rst_id", 32'(out_id), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid",   32'(out_valid),  32'd0);
    check("mid_rst_pending", 32'(pending),    32'd0);
    check("mid_rst_trap",    32'(trap_clear), 32'd0);
    model_reset();
    @(negedge outclk);
    reset = 1'b0;
    tick(4'b1111, 1'b1, 1'b0);
    tick(4'b0000, 1'b1, 1'b0);
    check("post_rst_id", 32'(out_id), 32'd0);
    for (int i = 0; i < 12; i++) tick(4'b0000, 1'b1, 1'b0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      logic [NUM_CH-1:0] ev;
      for (int i = 0; i < NUM_CH; i++) ev[i] = ($urandom_range(0, 99) < 15);
      cnt_sel = ID_W'($urandom_range(0, NUM_CH - 1));
      tick(ev, ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
